// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy flags, error pulses and optional FWFT read
module sync_fifo_flags #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic                       r_en,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             wr_ok;
    logic             rd_ok;

    // Acceptance is judged on the registered flags, so full+read frees no slot this edge.
    assign wr_ok = w_en && !full;
    assign rd_ok = r_en && !empty;

    assign count        = count_q;
    assign full         = (count_q == FULL_CNT);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= w_en && full;
            underflow <= r_en && empty;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is exposed directly; gating on empty hides unreset memory.
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[rd_ptr];
                end
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - directed self-checking bench for registered and FWFT FIFO variants
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] r_dout, f_dout;
    logic       r_full, r_empty, r_af, r_ae, r_ovf, r_unf;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [3:0] r_count, f_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_reg (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(r_dout), .full(r_full), .empty(r_empty), .almost_full(r_af),
        .almost_empty(r_ae), .count(r_count), .overflow(r_ovf), .underflow(r_unf)
    );

    sync_fifo_flags #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d);
        w_en    = w;
        r_en    = r;
        data_in = d;
        @(posedge clk);
        @(negedge clk);
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        check("rst_empty", r_empty, 1);
        check("rst_ae", r_ae, 1);
        check("rst_full", r_full, 0);
        check("rst_af", r_af, 0);
        check("rst_count", r_count, 0);
        check("rst_dout", r_dout, 8'h00);
        check("rst_fdout", f_dout, 8'h00);
        check("rst_ovf", r_ovf, 0);
        check("rst_unf", r_unf, 0);

        // fill 1..8, then a rejected ninth write
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 8'(i));
            check("fill_count", r_count, i);
            check("fill_af", r_af, (i >= 6));
            check("fill_full", r_full, (i == 8));
            check("fill_ae", r_ae, (i <= 2));
            check("fill_fhead", f_dout, 8'h01);
        end
        step(1, 0, 8'h09);
        check("ovf_pulse", r_ovf, 1);
        check("ovf_count", r_count, 8);
        check("ovf_fovf", f_ovf, 1);
        step(0, 0, 8'h00);
        check("ovf_clear", r_ovf, 0);

        // drain from full; FWFT head advances one word ahead
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 8'h00);
            check("drain_dout", r_dout, i);
            check("drain_count", r_count, 8 - i);
            check("drain_fdout", f_dout, (i < 8) ? i + 1 : 0);
        end
        check("drain_empty", r_empty, 1);
        step(0, 1, 8'h00);
        check("unf_pulse", r_unf, 1);
        check("unf_hold", r_dout, 8'h08);
        check("unf_count", r_count, 0);
        step(0, 0, 8'h00);
        check("unf_clear", r_unf, 0);

        // steady-state simultaneous traffic at occupancy 4, wrapping pointers
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h10 + i));
        check("lvl4_count", r_count, 4);
        for (int k = 0; k < 20; k++) begin
            step(1, 1, 8'(8'h14 + k));
            check("rw_count", r_count, 4);
            check("rw_dout", r_dout, 8'h10 + k);
            check("rw_fdout", f_dout, 8'h11 + k);
        end
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 8'h00);
            check("rw_tail", r_dout, 8'h24 + k);
        end
        check("rw_empty", r_empty, 1);

        // simultaneous request when empty: write wins, read rejected
        do_reset();
        step(1, 1, 8'h55);
        check("e_rw_count", r_count, 1);
        check("e_rw_unf", r_unf, 1);
        check("e_rw_dout", r_dout, 8'h00);
        check("e_rw_fdout", f_dout, 8'h55);
        for (int i = 0; i < 7; i++) step(1, 0, 8'(8'h56 + i));
        check("f_full", r_full, 1);
        // simultaneous request when full: read wins, write rejected
        step(1, 1, 8'h77);
        check("f_rw_count", r_count, 7);
        check("f_rw_ovf", r_ovf, 1);
        check("f_rw_dout", r_dout, 8'h55);
        for (int i = 0; i < 7; i++) step(0, 1, 8'h00);
        check("f_rw_last", r_dout, 8'h5C);
        check("f_rw_empty", r_empty, 1);

        // FWFT: word visible without a read, zero once drained
        do_reset();
        step(1, 0, 8'hA5);
        check("fw_show", f_dout, 8'hA5);
        check("fw_regdout", r_dout, 8'h00);
        step(0, 0, 8'h00);
        check("fw_hold", f_dout, 8'hA5);
        step(0, 1, 8'h00);
        check("fw_empty", f_empty, 1);
        check("fw_zero", f_dout, 8'h00);
        check("fw_regread", r_dout, 8'hA5);

        // asynchronous reset mid-operation
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i));
        check("ar_pre", r_count, 5);
        #1 rst = 1'b0;
        #1;
        check("ar_count", r_count, 0);
        check("ar_empty", r_empty, 1);
        check("ar_fdout", f_dout, 8'h00);
        check("ar_dout", r_dout, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        step(1, 0, 8'h3C);
        check("ar_fshow", f_dout, 8'h3C);
        step(0, 1, 8'h00);
        check("ar_read", r_dout, 8'h3C);
        check("ar_final", r_empty, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, almost_full threshold (1..DEPTH).
REQ-004 SHALL have parameter AE_LEVEL, default 2, almost_empty threshold (0..DEPTH-1).
REQ-005 SHALL have parameter FWFT, default 0, read mode (0 = registered read, 1 = first-word-fall-through).
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port w_en  input  1  write request.
REQ-009 SHALL have port r_en  input  1  read request.
REQ-010 SHALL have port data_in  input  WIDTH  write data.
REQ-011 SHALL have port data_out  output  WIDTH  read data.
REQ-012 SHALL have port full  output  1  count == DEPTH.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port almost_full  output  1  count >= AF_LEVEL.
REQ-015 SHALL have port almost_empty  output  1  count <= AE_LEVEL.
REQ-016 SHALL have port count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 SHALL have port overflow  output  1  one-cycle pulse: write rejected.
REQ-018 SHALL have port underflow  output  1  one-cycle pulse: read rejected.

Function
REQ-019 Write SHALL be accepted iff w_en=1 and full=0 at the clock edge; data_in stored at write pointer, write pointer increments modulo DEPTH.
REQ-020 Read SHALL be accepted iff r_en=1 and empty=0 at the clock edge; read pointer increments modulo DEPTH.
REQ-021 Acceptance SHALL be judged on pre-edge flags: simultaneous w_en/r_en when full -> read accepted, write rejected; when empty -> write accepted, read rejected.
REQ-022 Simultaneous accepted read and write SHALL leave count unchanged; otherwise count +1 per accepted write, -1 per accepted read.
REQ-023 full, empty, almost_full, almost_empty SHALL be derived from the registered count only (valid the cycle after the updating edge, no combinational path from w_en/r_en).
REQ-024 overflow SHALL be 1 for exactly the cycle after an edge with w_en=1 and full=1, else 0; underflow likewise for r_en=1 and empty=1.
REQ-025 Rejected operations SHALL not alter memory, pointers, count or data_out.
REQ-026 FWFT=0: data_out SHALL be registered, load the head entry on the edge of an accepted read (1-cycle latency), and hold its value otherwise.
REQ-027 FWFT=1: data_out SHALL show the head entry whenever empty=0 (no read needed), advance to the next entry the cycle after an accepted read, and be 0 when empty=1.
REQ-028 FWFT=1: a word written into an empty FIFO SHALL appear on data_out the cycle after the write edge.
REQ-029 Pointer wrap SHALL be seamless: entries written after wrap read back in FIFO order with no lost or duplicated word.
REQ-030 Data ordering SHALL be strict first-in first-out for all parameter values.

Reset
REQ-031 rst=0 SHALL immediately (asynchronously) clear pointers and count to 0.
REQ-032 During/after reset: empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, data_out=0.
REQ-033 Memory contents SHALL not be reset; no stale word SHALL ever be visible after reset.
REQ-034 Reset asserted mid-operation SHALL discard all stored data; first accepted write after release is the first word read.
REQ-035 Reset release SHALL take effect at the first rising clk edge with rst=1.

Verification (WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2)
REQ-036 Reset then idle -> empty=1, almost_empty=1, full=0, count=0, data_out=0x00.
REQ-037 Write 0x01..0x08 on 8 edges, then 1 more write 0x09 -> almost_full from count=6, full at count=8, overflow pulse 1 cycle, 0x09 never read.
REQ-038 Read 8 times from full (FWFT=0) -> data_out 0x01..0x08 each one cycle after its read edge; 9th read -> underflow pulse, data_out holds 0x08.
REQ-039 Fill 4, then 20 cycles of simultaneous w_en/r_en with incrementing data -> count stays 4, output order strict, pointers wrap with no loss.
REQ-040 FWFT=1, write 0xA5 into empty -> data_out=0xA5 next cycle with r_en=0; read -> empty=1, data_out=0x00.
REQ-041 Fill 5, assert rst=0 between clock edges -> count=0, empty=1 immediately; after release write 0x3C, read -> 0x3C.
